// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand/result bundle between a divider client and seq_divider.
interface seq_divider_if #(parameter int N = 8);
  logic start;
  logic [2*N-1:0] dividend;
  logic [N-1:0] divisor;
  logic busy;
  logic done;
  logic [2*N-1:0] quotient;
  logic [N-1:0] remainder;
  logic div_by_zero;
  modport master (
    output start, dividend, divisor,
    input busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock.
module seq_divider #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(2*N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [2*N-1:0] d, q, q_nxt;
  logic [N-1:0] v, r, r_nxt;
  logic [N:0] t;
  logic [CW-1:0] cnt;
  logic accept, zero, ge, last;
  logic [2*N-1:0] quotient;
  logic [N-1:0] remainder;
  logic div_by_zero;
  assign accept = bus.start && state != RUN;
  assign zero = bus.divisor == '0;
  assign last = state == RUN && cnt == '0;
  // R < V keeps the partial remainder within N bits, so only T needs the extra bit
  assign t = {r, d[2*N-1]};
  assign ge = t >= {1'b0, v};
  assign r_nxt = ge ? N'(t - {1'b0, v}) : t[N-1:0];
  assign q_nxt = {q[2*N-2:0], ge};
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.quotient = quotient;
  assign bus.remainder = remainder;
  assign bus.div_by_zero = div_by_zero;
  always_comb begin
    state_nxt = IDLE;
    state_nxt = accept ? (zero ? DONE : RUN) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0;
      v <= '0;
      r <= '0;
      q <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d <= bus.dividend;
      v <= bus.divisor;
      r <= '0;
      q <= '0;
      cnt <= CW'(2*N-1);
      if (zero) begin
        quotient <= '1;
        remainder <= bus.dividend[N-1:0];
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      d <= d << 1;
      r <= r_nxt;
      q <= q_nxt;
      cnt <= cnt - 1'b1;
      if (last) begin
        quotient <= q_nxt;
        remainder <= r_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential radix-2 restoring divider that undoes the product formed by the combinational Karatsuba multiplier. It takes a 2N-bit dividend, such as a multiplier output C = A*B, and an N-bit divisor. It returns the 2N-bit quotient and the N-bit remainder, producing one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath and is used for modular reduction and for checking products.

## Interface
- N, default 8: operand width. Must be a power of 2 and ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled on the rising edge.
- dividend  input  2N  unsigned dividend; captured when start is accepted.
- divisor  input  N  unsigned divisor; captured when start is accepted.
- busy  output  1  high while the division iterates (RUN state).
- done  output  1  single-cycle pulse; results valid in this cycle.
- quotient  output  2N  unsigned quotient; registered.
- remainder  output  N  unsigned remainder; registered.
- div_by_zero  output  1  high when the last accepted divisor was 0; registered.

## Operation
- States: IDLE, RUN, DONE.
- Reset forces IDLE and drives all outputs and internal registers to 0.
- IDLE or DONE with start=1:
  - Capture dividend into shift register D and divisor into V.
  - Clear partial remainder R (N+1 bits) and the quotient shift register.
  - Load bit counter = 2N-1.
  - If divisor == 0, go to DONE. Otherwise go to RUN.
- DONE with start=0 goes to IDLE.
- RUN step, once per cycle:
  - T = {R[N-1:0], D[2N-1]}, N+1 bits wide. Shift D left by 1.
  - If T ≥ {1'b0, V}: R = T - V and shift 1 into the quotient LSB. Otherwise R = T and shift 0 into the quotient LSB.
  - The bound R < V ≤ 2^N-1 guarantees T fits in N+1 bits and R[N] is always 0 after the step.
  - When counter == 0, go to DONE. Otherwise decrement the counter.
- Output loading on the transition into DONE:
  - Normal division: quotient = final quotient register; remainder = R[N-1:0]; div_by_zero = 0.
  - Divide by zero: quotient = all ones; remainder = dividend[N-1:0]; div_by_zero = 1.
- quotient, remainder and div_by_zero hold their values until the next transition into DONE or until reset.
- start in RUN is ignored, with no effect on the state or the captured operands.
- Changes to dividend or divisor after the accepting edge have no effect.
- Invariant for a nonzero divisor: quotient*divisor + remainder == dividend, and remainder < divisor.

## Timing
- start accepted at edge t with a nonzero divisor:
  - busy=1 in cycles t+1 … t+2N.
  - done=1 and results valid in cycle t+2N+1.
  - Latency is 2N+1 cycles; for N=8, done arrives 17 cycles after the accepting edge.
- Divide by zero: busy is never asserted; done=1 in cycle t+1.
- Back-to-back operation: start=1 during the DONE cycle is accepted. The next operation begins without an IDLE cycle, giving a throughput of one result per 2N+1 cycles.
- busy and done are never high in the same cycle.
- done is high for exactly one cycle per accepted start.
- Reset asserted mid-RUN:
  - The state goes to IDLE immediately, without waiting for a clock edge.
  - The operation in progress is discarded and no done is produced.
  - Outputs read 0 until the next completed operation.
- start held high in IDLE starts exactly one operation. A new operation is accepted only in the DONE cycle, if start is still high then.

## Test plan
- N=8, dividend=0x0C35 (3125), divisor=25 -> done exactly 17 cycles after start; quotient=0x007D (125); remainder=0; div_by_zero=0.
- dividend=1000, divisor=7 -> quotient=142, remainder=6. Also dividend=0xFFFF, divisor=0x01 -> quotient=0xFFFF, remainder=0. Also dividend=0xFFFF, divisor=0xFF -> quotient=0x0101, remainder=0.
- Divide by zero: dividend=0x1234, divisor=0 -> done one cycle after start; busy never high; quotient=0xFFFF; remainder=0x34; div_by_zero=1.
- Inverse of the multiplier: 1000 random pairs A, B with B≠0:
  - dividend = Karatsuba product of A and B -> quotient=A, remainder=0.
  - dividend = A*B + (B-1) -> quotient=A, remainder=B-1.
  - Run these back-to-back, with start held high through each DONE cycle.
- Pulse start mid-RUN with different operands -> ignored; the result matches the first operands.
- Assert rst at cycle t+5 of a running operation -> busy, done, quotient, remainder and div_by_zero all 0 immediately, with no done pulse. A fresh start after release of rst (3125/25) -> correct result with 17-cycle latency.
